trigger_release_sequencer: RTL and testbench
============================================

Name: trigger_release_sequencer

Overview:
- Initiator-side controller for the clock-enable gate. The gate drops its clock enable a fixed delay after a trigger and holds it low until a release.
- On a start request, this block issues the trigger and watches the returned clock-enable level. It holds the gated period for a programmable number of cycles, then issues the release and confirms the enable has returned high.
- Sits between a control/debug source (start, hold length) and the gate's trigger/release inputs, and reports completion or timeout.

Parameters:
- TRIGGER_EDGE, 1'b1, active level driven on trigger_o; idle level is its inverse.
- RELEASE_EDGE, 1'b1, active level driven on release_o; idle level is its inverse.
- HOLD_W, 16, width of hold_cycles_i and the hold counter.
- TIMEOUT, 256, max cycles spent in WAIT_GATE or in WAIT_UNGATE before abort; must be >= 2.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous reset, active low
- start_i  input  1  request a gate/hold/release sequence; sampled only in IDLE
- hold_cycles_i  input  HOLD_W  gated-period length in cycles; latched when start is accepted
- ce_i  input  1  clock-enable level returned by the gate
- trigger_o  output  1  trigger to gate, registered
- release_o  output  1  release to gate, registered
- busy_o  output  1  high in every state except IDLE
- done_o  output  1  one-cycle pulse on successful completion
- error_o  output  1  sticky timeout flag; cleared when the next start is accepted

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; trigger_o=~TRIGGER_EDGE; release_o=~RELEASE_EDGE; busy_o=0; done_o=0; error_o=0; all counters 0.
  - Reset mid-sequence aborts immediately with no release issued.
- Outputs: all registered; trigger_o/release_o are never both active in the same cycle.
- IDLE:
  - start_i=1 → latch hold_cycles_i, clear error_o, clear timeout counter, go TRIGGER.
  - start_i=0 → stay.
- TRIGGER: trigger_o active for exactly this one cycle, then go WAIT_GATE.
- WAIT_GATE:
  - ce_i=0 sampled → load hold counter with the latched value and clear the timeout counter. Go HOLD, or go RELEASE if latched hold == 0.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT, set error_o and go IDLE with no release and no done.
- HOLD:
  - Decrement the hold counter each cycle; on the cycle it reaches 1, go RELEASE.
  - release_o first becomes active exactly hold+1 cycles after the cycle ce_i was first sampled low.
- RELEASE: release_o active; go WAIT_UNGATE.
- WAIT_UNGATE:
  - release_o stays active (level hold) while here.
  - ce_i=1 sampled → release_o inactive next cycle, done_o=1 for one cycle, go IDLE.
  - Otherwise count; on TIMEOUT cycles, set error_o, deassert release_o, go IDLE with no done.
- ce_i rising during HOLD (gate released by another agent): ignored; the sequence continues and WAIT_UNGATE completes on its first cycle.
- start_i while busy_o=1: ignored, not queued.
- start_i high in the cycle done_o pulses: that cycle is IDLE, so start is accepted and a new sequence begins.
- Counter widths:
  - Timeout counter is $clog2(TIMEOUT+1) bits and saturates, never wraps.
  - Hold counter is HOLD_W bits; the maximum hold is 2^HOLD_W-1.
- ce_i is assumed synchronous to clk (same domain as the gate); no synchronizer is included.

Test Plan:
- Nominal:
  - Stimulus: hold_cycles_i=3, start pulse at cycle 0; model drives ce_i low from cycle 5 and high the cycle after first seeing release.
  - Required: trigger_o active at cycle 1 only; release_o active from cycle 9 until ce_i seen high; done_o single pulse; error_o=0; busy_o high from cycle 1 to the done cycle.
- Zero hold:
  - Stimulus: hold_cycles_i=0, ce_i low 3 cycles after trigger.
  - Required: release_o active 1 cycle after ce_i first sampled low.
- Gate timeout:
  - Stimulus: TIMEOUT=16, ce_i held high forever.
  - Required: error_o set 16 cycles into WAIT_GATE; release_o never active; busy_o=0 afterwards; the next start clears error_o.
- Ungate timeout:
  - Stimulus: ce_i stays low after release.
  - Required: after TIMEOUT cycles release_o goes inactive, error_o=1, done_o never pulses.
- Ignored start and back-to-back:
  - Stimulus: start_i held high for the whole sequence.
  - Required: exactly one trigger per sequence; a second sequence's trigger_o occurs 1 cycle after done_o.
- Reset mid-HOLD:
  - Stimulus: assert rst_n=0 in HOLD.
  - Required: trigger_o/release_o at inactive levels immediately (async); busy_o=0; error_o=0; done_o=0.
  - Also rerun the nominal scenario with TRIGGER_EDGE=0, RELEASE_EDGE=0 and check the inverted levels.

Source files
------------

// File: rtl/trigger_release_sequencer.sv
// trigger_release_sequencer
// Initiator-side controller for a clock-enable gate. A start request issues a
// one-cycle trigger, waits for the gate to drop its enable, holds the gated
// period for a latched number of cycles, then drives release until the enable
// returns high. Both waits are bounded by TIMEOUT; expiry raises a sticky error.
// All outputs are registered. Output values are computed from the next state,
// so each output lines up exactly with the state it belongs to.
module trigger_release_sequencer #(
  parameter logic TRIGGER_EDGE = 1'b1,  // active level of trigger_o
  parameter logic RELEASE_EDGE = 1'b1,  // active level of release_o
  parameter int   HOLD_W       = 16,    // hold length / hold counter width
  parameter int   TIMEOUT      = 256    // max cycles in either wait state, >= 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [HOLD_W-1:0] hold_cycles_i,
  input  logic              ce_i,
  output logic              trigger_o,
  output logic              release_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o
);

  // The timeout counter must be able to represent TIMEOUT itself so that it
  // can saturate there rather than wrap.
  localparam int TO_W = $clog2(TIMEOUT + 1);

  localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]   TO_ONE   = TO_W'(1);
  localparam logic [TO_W-1:0]   TO_ZERO  = '0;
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = '0;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_TRIGGER     = 3'd1,
    S_WAIT_GATE   = 3'd2,
    S_HOLD        = 3'd3,
    S_RELEASE     = 3'd4,
    S_WAIT_UNGATE = 3'd5
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [HOLD_W-1:0] hold_latch;
  logic [HOLD_W-1:0] hold_cnt;
  logic [TO_W-1:0]   to_cnt;

  logic start_accept;
  logic gate_seen;
  logic ungate_seen;
  logic waiting;
  logic to_expire;
  logic timeout_abort;

  logic trigger_d;
  logic release_d;
  logic busy_d;
  logic done_d;
  logic error_d;

  // Saturating increment: the counter stops at TIMEOUT instead of wrapping.
  function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] v);
    logic [TO_W-1:0] r;
    if (v >= TO_MAX) r = TO_MAX;
    else             r = v + TO_ONE;
    return r;
  endfunction

  // Qualified events shared by the next-state, output and counter logic.
  always_comb begin
    start_accept  = (state == S_IDLE) && start_i;
    gate_seen     = (state == S_WAIT_GATE) && !ce_i;
    ungate_seen   = (state == S_WAIT_UNGATE) && ce_i;
    // Cycles that count toward the timeout: still waiting for the gate edge.
    waiting       = ((state == S_WAIT_GATE) && ce_i) ||
                    ((state == S_WAIT_UNGATE) && !ce_i);
    // The current waiting cycle is the TIMEOUT-th one in this wait state.
    to_expire     = (to_cnt >= TO_LAST);
    timeout_abort = waiting && to_expire;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start_i) state_nxt = S_TRIGGER;
      end
      S_TRIGGER: begin
        state_nxt = S_WAIT_GATE;
      end
      S_WAIT_GATE: begin
        if (!ce_i) begin
          // A zero-length hold skips the gated period entirely.
          if (hold_latch == HOLD_ZERO) state_nxt = S_RELEASE;
          else                         state_nxt = S_HOLD;
        end else if (to_expire) begin
          state_nxt = S_IDLE;
        end
      end
      S_HOLD: begin
        // The counter is loaded with the hold length and the last HOLD cycle
        // is the one where it reads 1; ce_i is deliberately ignored here.
        if (hold_cnt <= HOLD_ONE) state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        state_nxt = S_WAIT_UNGATE;
      end
      S_WAIT_UNGATE: begin
        if (ce_i || to_expire) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Output logic: next-cycle values of the registered outputs.
  always_comb begin
    trigger_d = (state_nxt == S_TRIGGER) ? TRIGGER_EDGE : ~TRIGGER_EDGE;
    // Release is a level held through RELEASE and WAIT_UNGATE; trigger is
    // only active in TRIGGER, so the two can never be active together.
    release_d = ((state_nxt == S_RELEASE) || (state_nxt == S_WAIT_UNGATE)) ?
                RELEASE_EDGE : ~RELEASE_EDGE;
    busy_d    = (state_nxt != S_IDLE);
    done_d    = ungate_seen;
    error_d   = error_o;
    if (start_accept)       error_d = 1'b0;
    else if (timeout_abort) error_d = 1'b1;
  end

  // Registered outputs; reset leaves trigger/release at their idle levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trigger_o <= ~TRIGGER_EDGE;
      release_o <= ~RELEASE_EDGE;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      error_o   <= 1'b0;
    end else begin
      trigger_o <= trigger_d;
      release_o <= release_d;
      busy_o    <= busy_d;
      done_o    <= done_d;
      error_o   <= error_d;
    end
  end

  // Hold length is captured at start so later changes on the input are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            hold_latch <= HOLD_ZERO;
    else if (start_accept) hold_latch <= hold_cycles_i;
  end

  // Hold counter: loaded when the gate closes, counts down through HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= HOLD_ZERO;
    end else if (gate_seen) begin
      hold_cnt <= hold_latch;
    end else if ((state == S_HOLD) && (hold_cnt != HOLD_ZERO)) begin
      hold_cnt <= hold_cnt - HOLD_ONE;
    end
  end

  // Timeout counter: cleared on start and when the gate closes, so each wait
  // state gets its own TIMEOUT budget; counts only while still waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= TO_ZERO;
    end else if (start_accept || gate_seen) begin
      to_cnt <= TO_ZERO;
    end else if (waiting) begin
      to_cnt <= sat_inc(to_cnt);
    end
  end

endmodule

// File: tb/tb_trigger_release_sequencer.sv
// Testbench for trigger_release_sequencer. Two instances share the stimulus:
// one with active-high trigger/release, one with both edges inverted.
// Expected waveforms are derived per sequence from event times (start, first
// low ce sample, ce rise) with plain arithmetic.
module tb_trigger_release_sequencer;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [15:0] hold_cycles_i;
  logic        ce_i;

  logic trigger_o, release_o, busy_o, done_o, error_o;
  logic trigger_n, release_n, busy_n, done_n, error_n;

  int checks = 0;
  int errors = 0;

  // Expected done/error in the first idle cycle after a sequence.
  logic pend_done = 1'b0;
  logic pend_err  = 1'b0;

  always #5 clk = ~clk;

  trigger_release_sequencer #(
    .TRIGGER_EDGE(1'b1), .RELEASE_EDGE(1'b1), .HOLD_W(16), .TIMEOUT(T)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .hold_cycles_i(hold_cycles_i),
    .ce_i(ce_i), .trigger_o(trigger_o), .release_o(release_o), .busy_o(busy_o),
    .done_o(done_o), .error_o(error_o)
  );

  trigger_release_sequencer #(
    .TRIGGER_EDGE(1'b0), .RELEASE_EDGE(1'b0), .HOLD_W(16), .TIMEOUT(T)
  ) dut_n (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .hold_cycles_i(hold_cycles_i),
    .ce_i(ce_i), .trigger_o(trigger_n), .release_o(release_n), .busy_o(busy_n),
    .done_o(done_n), .error_o(error_n)
  );

  // One full sequence starting in an idle cycle (cycle 0 = start sampled).
  // d: ce first low at cycle 2+d (d >= T means ce never drops).
  // rise: cycle at which ce returns high.
  task automatic run_seq(input int hold, input int d, input int rise, input bit keep_start,
                         output int first_rel, output int trig_cnt);
    int g, r, e, rel_hi, s;
    bit gto, uto;
    logic et, er, eb, ed, ee;
    gto = (d >= T);
    uto = 1'b0;
    g = 2 + d;
    r = g + hold + 1;
    if (gto) begin
      e = T + 1; r = -1; rel_hi = -2;
    end else begin
      s = (rise > r + 1) ? rise : r + 1;
      if (s - (r + 1) < T) begin e = s; rel_hi = s; end
      else begin uto = 1'b1; e = r + T; rel_hi = r + T; end
    end
    first_rel = -1;
    trig_cnt  = 0;
    for (int c = 0; c <= e; c++) begin
      start_i       = (c == 0) ? 1'b1 : (keep_start ? 1'b1 : 1'($urandom_range(0, 1)));
      hold_cycles_i = (c == 0) ? 16'(hold) : 16'($urandom);
      ce_i          = (!gto && c >= g && c < rise) ? 1'b0 : 1'b1;
      @(negedge clk);
      et = (c == 1);
      er = (c >= r && c <= rel_hi);
      eb = (c >= 1);
      ed = (c == 0) ? pend_done : 1'b0;
      ee = (c == 0) ? pend_err : 1'b0;
      checks += 10;
      if (trigger_o !== et) begin errors++; $display("FAIL seq trigger c=%0d got %b exp %b", c, trigger_o, et); end
      if (release_o !== er) begin errors++; $display("FAIL seq release c=%0d got %b exp %b", c, release_o, er); end
      if (busy_o !== eb) begin errors++; $display("FAIL seq busy c=%0d got %b exp %b", c, busy_o, eb); end
      if (done_o !== ed) begin errors++; $display("FAIL seq done c=%0d got %b exp %b", c, done_o, ed); end
      if (error_o !== ee) begin errors++; $display("FAIL seq error c=%0d got %b exp %b", c, error_o, ee); end
      if (trigger_n !== ~et) begin errors++; $display("FAIL inv trigger c=%0d got %b exp %b", c, trigger_n, ~et); end
      if (release_n !== ~er) begin errors++; $display("FAIL inv release c=%0d got %b exp %b", c, release_n, ~er); end
      if (busy_n !== eb) begin errors++; $display("FAIL inv busy c=%0d got %b exp %b", c, busy_n, eb); end
      if (done_n !== ed) begin errors++; $display("FAIL inv done c=%0d got %b exp %b", c, done_n, ed); end
      if (error_n !== ee) begin errors++; $display("FAIL inv error c=%0d got %b exp %b", c, error_n, ee); end
      if (trigger_o === 1'b1) trig_cnt++;
      if (release_o === 1'b1 && first_rel < 0) first_rel = c;
      @(posedge clk); #1;
    end
    pend_done = !gto && !uto;
    pend_err  = gto || uto;
  endtask

  task automatic test_idle(input int n);
    logic ed;
    for (int i = 0; i < n; i++) begin
      start_i       = 1'b0;
      ce_i          = 1'($urandom_range(0, 1));
      hold_cycles_i = 16'($urandom);
      @(negedge clk);
      ed = (i == 0) ? pend_done : 1'b0;
      checks += 6;
      if (busy_o !== 1'b0 || busy_n !== 1'b0) begin errors++; $display("FAIL idle busy i=%0d got %b/%b exp 0", i, busy_o, busy_n); end
      if (trigger_o !== 1'b0 || trigger_n !== 1'b1) begin errors++; $display("FAIL idle trigger i=%0d got %b/%b exp 0/1", i, trigger_o, trigger_n); end
      if (release_o !== 1'b0 || release_n !== 1'b1) begin errors++; $display("FAIL idle release i=%0d got %b/%b exp 0/1", i, release_o, release_n); end
      if (done_o !== ed || done_n !== ed) begin errors++; $display("FAIL idle done i=%0d got %b/%b exp %b", i, done_o, done_n, ed); end
      if (error_o !== pend_err) begin errors++; $display("FAIL idle error i=%0d got %b exp %b", i, error_o, pend_err); end
      if (error_n !== pend_err) begin errors++; $display("FAIL idle inv error i=%0d got %b exp %b", i, error_n, pend_err); end
      @(posedge clk); #1;
    end
    pend_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b1; ce_i = 1'b1; hold_cycles_i = 16'd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 5;
    if (trigger_o !== 1'b0 || trigger_n !== 1'b1) begin errors++; $display("FAIL reset trigger got %b/%b exp 0/1", trigger_o, trigger_n); end
    if (release_o !== 1'b0 || release_n !== 1'b1) begin errors++; $display("FAIL reset release got %b/%b exp 0/1", release_o, release_n); end
    if (busy_o !== 1'b0 || busy_n !== 1'b0) begin errors++; $display("FAIL reset busy got %b/%b exp 0", busy_o, busy_n); end
    if (done_o !== 1'b0 || done_n !== 1'b0) begin errors++; $display("FAIL reset done got %b/%b exp 0", done_o, done_n); end
    if (error_o !== 1'b0 || error_n !== 1'b0) begin errors++; $display("FAIL reset error got %b/%b exp 0", error_o, error_n); end
    @(posedge clk); #1;
    rst_n = 1'b1; start_i = 1'b0;
    pend_done = 1'b0; pend_err = 1'b0;
    test_idle(2);
  endtask

  task automatic test_nominal();
    int fr, tc;
    run_seq(3, 3, 10, 1'b0, fr, tc);
    checks += 2;
    if (fr !== 9) begin errors++; $display("FAIL nominal first release cycle got %0d exp 9", fr); end
    if (tc !== 1) begin errors++; $display("FAIL nominal trigger count got %0d exp 1", tc); end
    test_idle(2);
  endtask

  task automatic test_zero_hold();
    int fr, tc;
    // ce low 3 cycles after the trigger cycle -> first low sample at cycle 4
    run_seq(0, 2, 6, 1'b0, fr, tc);
    checks++;
    if (fr !== 5) begin errors++; $display("FAIL zero_hold first release cycle got %0d exp 5", fr); end
    test_idle(2);
  endtask

  task automatic test_gate_timeout();
    int fr, tc;
    run_seq(4, T, 0, 1'b0, fr, tc);
    checks++;
    if (fr !== -1) begin errors++; $display("FAIL gate_timeout release seen at %0d exp none", fr); end
    test_idle(3);
    // next start must clear the sticky error (checked from cycle 1 on)
    run_seq(2, 1, 7, 1'b0, fr, tc);
    test_idle(1);
  endtask

  task automatic test_ungate_timeout();
    int fr, tc;
    run_seq(2, 1, 100000, 1'b0, fr, tc);
    checks++;
    if (fr !== 6) begin errors++; $display("FAIL ungate_timeout first release cycle got %0d exp 6", fr); end
    test_idle(3);
  endtask

  task automatic test_back_to_back();
    int fr, tc;
    for (int k = 0; k < 3; k++) begin
      run_seq(k, 0, 3 + k + 2, 1'b1, fr, tc);
      checks++;
      if (tc !== 1) begin errors++; $display("FAIL back_to_back seq %0d trigger count got %0d exp 1", k, tc); end
    end
    test_idle(2);
  endtask

  task automatic test_reset_mid_hold();
    // start at cycle 0, ce low from cycle 3, hold=20 -> HOLD from cycle 4
    for (int c = 0; c < 8; c++) begin
      start_i       = (c == 0) ? 1'b1 : 1'b0;
      hold_cycles_i = (c == 0) ? 16'd20 : 16'($urandom);
      ce_i          = (c >= 3) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    checks += 5;
    if (trigger_o !== 1'b0 || trigger_n !== 1'b1) begin errors++; $display("FAIL rst_hold trigger got %b/%b exp 0/1", trigger_o, trigger_n); end
    if (release_o !== 1'b0 || release_n !== 1'b1) begin errors++; $display("FAIL rst_hold release got %b/%b exp 0/1", release_o, release_n); end
    if (busy_o !== 1'b0 || busy_n !== 1'b0) begin errors++; $display("FAIL rst_hold busy got %b/%b exp 0", busy_o, busy_n); end
    if (done_o !== 1'b0 || done_n !== 1'b0) begin errors++; $display("FAIL rst_hold done got %b/%b exp 0", done_o, done_n); end
    if (error_o !== 1'b0 || error_n !== 1'b0) begin errors++; $display("FAIL rst_hold error got %b/%b exp 0", error_o, error_n); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    // no release may follow the aborted sequence
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      checks++;
      if (release_o !== 1'b0 || busy_o !== 1'b0) begin
        errors++; $display("FAIL rst_hold after i=%0d release/busy got %b/%b exp 0/0", i, release_o, busy_o);
      end
      @(posedge clk); #1;
    end
    ce_i = 1'b1;
    pend_done = 1'b0; pend_err = 1'b0;
    test_idle(1);
  endtask

  task automatic test_random();
    int fr, tc, hold, d, rise, kind;
    for (int k = 0; k < 30; k++) begin
      hold = int'($urandom_range(0, 8));
      kind = int'($urandom_range(0, 9));
      if (kind == 0) d = T + int'($urandom_range(0, 2));
      else           d = int'($urandom_range(0, 10));
      if (kind == 1) rise = 100000;
      else           rise = 2 + d + 1 + int'($urandom_range(0, hold + 4));
      run_seq(hold, d, rise, 1'($urandom_range(0, 1)), fr, tc);
      checks++;
      if (tc !== 1) begin errors++; $display("FAIL random seq %0d trigger count got %0d exp 1", k, tc); end
      if ($urandom_range(0, 2) != 0) test_idle(int'($urandom_range(1, 3)));
    end
    test_idle(2);
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; ce_i = 1'b1; hold_cycles_i = '0;
    test_reset();
    test_nominal();
    test_zero_hold();
    test_gate_timeout();
    test_ungate_timeout();
    test_back_to_back();
    test_reset_mid_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
